// File: rtl/router_pkg.sv
// Shared router types and sizing constants used by the output-port schedulers
// and allocators.
package router_pkg;

  localparam int NUM_VCS           = 4;
  localparam int VC_ID_BITS        = 2;
  localparam int DIM_BITS          = 4;
  localparam int BUF_DEPTH_DEFAULT = 4;

  typedef enum logic [2:0] {
    L = 3'd0,
    N = 3'd1,
    E = 3'd2,
    S = 3'd3,
    W = 3'd4
  } dir_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or after ptr,
// wrapping modulo N, receives a one-hot grant and its binary index.
module rr_arbiter #(
  parameter int N       = 4,
  parameter int ID_BITS = (N > 1) ? $clog2(N) : 1
) (
  input  logic               req [N],
  input  logic [ID_BITS-1:0] ptr,
  output logic               grant [N],
  output logic [ID_BITS-1:0] grant_id
);

  logic found;
  int   idx;

  always_comb begin
    grant    = '{default: 1'b0};
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int i = 0; i < N; i++) begin
      // Explicit modulo so non-power-of-two N wraps correctly.
      idx = (int'(ptr) + i) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_BITS'(idx);
      end
    end
  end

endmodule

// File: rtl/vc_output_sched.sv
// Per-output-port VC scheduler: round-robin among requesting VCs that hold
// downstream credit, with per-VC credit counters and a sticky error flag.
module vc_output_sched
  import router_pkg::*;
#(
  parameter dir_t LOCAL_PORT = E,
  parameter int   BUF_DEPTH  = BUF_DEPTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
`ifndef SYNTHESIS
  input  logic [DIM_BITS-1:0]   LOCAL_X,
  input  logic [DIM_BITS-1:0]   LOCAL_Y,
`endif
  input  logic                  vc_req [NUM_VCS],
  input  logic                  out_ready,
  input  logic                  credit_in,
  input  logic [VC_ID_BITS-1:0] credit_vc,
  output logic                  out_vc_selected [NUM_VCS],
  output logic                  out_valid,
  output logic [VC_ID_BITS-1:0] out_vc_id,
  output logic                  credit_err
);

  localparam int CRED_BITS = $clog2(BUF_DEPTH + 1);

  logic [CRED_BITS-1:0]  cred [NUM_VCS];
  logic [VC_ID_BITS-1:0] ptr;
  logic                  elig [NUM_VCS];
  logic                  accept;
  logic                  credit_vc_ok;

  always_comb begin
    out_valid = 1'b0;
    for (int v = 0; v < NUM_VCS; v++) begin
      elig[v]   = vc_req[v] && (cred[v] != '0);
      out_valid = out_valid | elig[v];
    end
  end

  rr_arbiter #(
    .N       (NUM_VCS),
    .ID_BITS (VC_ID_BITS)
  ) u_arb (
    .req      (elig),
    .ptr      (ptr),
    .grant    (out_vc_selected),
    .grant_id (out_vc_id)
  );

  assign accept       = out_valid && out_ready;
  assign credit_vc_ok = {1'b0, credit_vc} < (VC_ID_BITS + 1)'(NUM_VCS);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cred       <= '{default: CRED_BITS'(BUF_DEPTH)};
      ptr        <= '0;
      credit_err <= 1'b0;
    end else begin
      for (int v = 0; v < NUM_VCS; v++) begin
        // A credit and an accept on the same VC cancel, even at full count.
        if (credit_in && credit_vc_ok && (int'(credit_vc) == v) &&
            !(accept && (int'(out_vc_id) == v))) begin
          if (cred[v] == CRED_BITS'(BUF_DEPTH)) credit_err <= 1'b1;
          else cred[v] <= cred[v] + 1'b1;
        end else if (accept && (int'(out_vc_id) == v) &&
                     !(credit_in && credit_vc_ok && (int'(credit_vc) == v))) begin
          cred[v] <= cred[v] - 1'b1;
        end
      end
      if (credit_in && !credit_vc_ok) credit_err <= 1'b1;
      if (accept) begin
        ptr <= (out_vc_id == VC_ID_BITS'(NUM_VCS - 1)) ? '0 : out_vc_id + 1'b1;
      end
    end
  end

`ifndef SYNTHESIS
  logic [NUM_VCS-1:0] sel_vec;

  always_comb begin
    for (int v = 0; v < NUM_VCS; v++) sel_vec[v] = out_vc_selected[v];
  end

  always @(posedge clk) begin
    if (rst_n) begin
      assert ($countones(sel_vec) <= 1)
        else $error("vc_output_sched %s (%0d,%0d): grant not one-hot %b",
                    LOCAL_PORT.name(), LOCAL_X, LOCAL_Y, sel_vec);
      assert (out_valid == (|sel_vec))
        else $error("vc_output_sched %s (%0d,%0d): out_valid disagrees with grant",
                    LOCAL_PORT.name(), LOCAL_X, LOCAL_Y);
      for (int v = 0; v < NUM_VCS; v++) begin
        assert (!(sel_vec[v] && cred[v] == '0))
          else $error("vc_output_sched %s (%0d,%0d): grant to VC%0d without credit",
                      LOCAL_PORT.name(), LOCAL_X, LOCAL_Y, v);
      end
    end
  end
`endif

endmodule

// File: tb/tb_vc_output_sched.sv
// Directed bench for vc_output_sched with NUM_VCS=4, BUF_DEPTH=4: round-robin
// order, credit exhaustion/return, stalls, credit errors and reset.
module tb_vc_output_sched;
  import router_pkg::*;

  logic                  clk;
  logic                  rst_n;
  logic [DIM_BITS-1:0]   local_x;
  logic [DIM_BITS-1:0]   local_y;
  logic                  vc_req [NUM_VCS];
  logic                  out_ready;
  logic                  credit_in;
  logic [VC_ID_BITS-1:0] credit_vc;
  logic                  out_vc_selected [NUM_VCS];
  logic                  out_valid;
  logic [VC_ID_BITS-1:0] out_vc_id;
  logic                  credit_err;

  int vectors;
  int miscompares;

  vc_output_sched #(
    .LOCAL_PORT (E),
    .BUF_DEPTH  (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .LOCAL_X         (local_x),
    .LOCAL_Y         (local_y),
    .vc_req          (vc_req),
    .out_ready       (out_ready),
    .credit_in       (credit_in),
    .credit_vc       (credit_vc),
    .out_vc_selected (out_vc_selected),
    .out_valid       (out_valid),
    .out_vc_id       (out_vc_id),
    .credit_err      (credit_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic set_req(input logic [3:0] r);
    for (int v = 0; v < NUM_VCS; v++) vc_req[v] = r[v];
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    set_req(4'b0000);
    out_ready = 1'b0;
    credit_in = 1'b0;
    credit_vc = '0;
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [3:0] sel_vec();
    logic [3:0] s;
    for (int v = 0; v < NUM_VCS; v++) s[v] = out_vc_selected[v];
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
      else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic chk_grant(input string tag, input int id);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_id"},    32'(out_vc_id), 32'(id));
    chk({tag, "_sel"},   32'(sel_vec()), 32'(4'b0001 << id));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_id"},    32'(out_vc_id), 32'd0);
    chk({tag, "_sel"},   32'(sel_vec()), 32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    local_x     = 4'd1;
    local_y     = 4'd2;
    do_reset();
    do_reset();

    // Reset state
    settle();
    chk_idle("rst");
    chk("rst_err", 32'(credit_err), 32'd0);
    chk("rst_ptr", 32'(dut.ptr), 32'd0);
    for (int v = 0; v < NUM_VCS; v++) chk($sformatf("rst_cred%0d", v), 32'(dut.cred[v]), 32'd4);

    // All VCs requesting: strict rotation 0,1,2,3
    set_req(4'b1111);
    out_ready = 1'b1;
    settle();
    for (int k = 0; k < 4; k++) begin
      chk_grant($sformatf("rr%0d", k), k);
      tick();
    end
    for (int v = 0; v < NUM_VCS; v++) chk($sformatf("rr_cred%0d", v), 32'(dut.cred[v]), 32'd3);
    chk_grant("rr_wrap", 0);

    // Single requester drains its four credits, then one returned credit
    do_reset();
    set_req(4'b0100);
    out_ready = 1'b1;
    settle();
    for (int k = 0; k < 4; k++) begin
      chk_grant($sformatf("drain%0d", k), 2);
      tick();
    end
    chk_idle("drain_empty");
    credit_in = 1'b1;
    credit_vc = 2'd2;
    settle();
    chk_idle("drain_ret_same_cycle");
    tick();
    credit_in = 1'b0;
    settle();
    chk_grant("drain_ret_next", 2);
    tick();
    chk_idle("drain_empty2");

    // Stall with out_ready low, then release
    do_reset();
    set_req(4'b1111);
    out_ready = 1'b0;
    settle();
    for (int k = 0; k < 5; k++) begin
      chk_grant($sformatf("stall%0d", k), 0);
      tick();
    end
    chk("stall_ptr", 32'(dut.ptr), 32'd0);
    chk("stall_cred0", 32'(dut.cred[0]), 32'd4);
    out_ready = 1'b1;
    settle();
    chk_grant("release0", 0);
    tick();
    chk_grant("release1", 1);
    out_ready = 1'b0;

    // VC1 out of credit is skipped; same-cycle credit revives it
    do_reset();
    set_req(4'b0010);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    set_req(4'b0001);
    tick();
    chk("skip_ptr", 32'(dut.ptr), 32'd1);
    chk("skip_cred1", 32'(dut.cred[1]), 32'd0);
    set_req(4'b0011);
    credit_in = 1'b1;
    credit_vc = 2'd1;
    settle();
    chk_grant("skip_vc0", 0);
    tick();
    credit_in = 1'b0;
    settle();
    chk_grant("skip_vc1", 1);

    // Credit overflow is sticky and saturates
    do_reset();
    credit_in = 1'b1;
    credit_vc = 2'd3;
    tick();
    credit_in = 1'b0;
    settle();
    chk("ovf_err", 32'(credit_err), 32'd1);
    chk("ovf_cred3", 32'(dut.cred[3]), 32'd4);
    tick();
    chk("ovf_sticky", 32'(credit_err), 32'd1);

    // Credit plus accept on the same full VC is a net no-op
    do_reset();
    chk("ovf_cleared", 32'(credit_err), 32'd0);
    set_req(4'b1000);
    out_ready = 1'b1;
    credit_in = 1'b1;
    credit_vc = 2'd3;
    settle();
    chk_grant("net0", 3);
    tick();
    credit_in = 1'b0;
    out_ready = 1'b0;
    settle();
    chk("net0_cred3", 32'(dut.cred[3]), 32'd4);
    chk("net0_err", 32'(credit_err), 32'd0);

    // Reset mid-stream restores credits and pointer
    do_reset();
    set_req(4'b0100);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) tick();
    chk("mid_cred2", 32'(dut.cred[2]), 32'd1);
    chk("mid_ptr", 32'(dut.ptr), 32'd3);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b0;
    settle();
    chk("mid_rst_cred2", 32'(dut.cred[2]), 32'd4);
    chk("mid_rst_ptr", 32'(dut.ptr), 32'd0);
    chk("mid_rst_err", 32'(credit_err), 32'd0);
    chk_grant("mid_rst_grant", 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
